// File: rtl/i2c_target.sv
// I2C target (slave): oversampled SCL/SDA, START/STOP detection, fixed 7-bit address,
// write bytes handed out on rx_data/rx_valid, read bytes fetched from tx_data via tx_load.
module i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       I2C_SCL,
    inout  wire        I2C_SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t      state, state_nx;
    logic        scl_s1, scl_s2, scl_p;
    logic        sda_s1, sda_s2, sda_p;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  shift;
    logic [7:0]  byte_in;
    logic [3:0]  cnt;
    logic        sda_oe;
    logic        sda_low;
    logic        addr_hit;
    logic        last_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_p <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_p <= 1'b1;
        end else begin
            scl_s1 <= I2C_SCL; scl_s2 <= scl_s1; scl_p <= scl_s2;
            sda_s1 <= I2C_SDA; sda_s2 <= sda_s1; sda_p <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_p;
    assign scl_fall  = ~scl_s2 & scl_p;
    assign start_det = scl_s2 & scl_p & sda_p & ~sda_s2;
    assign stop_det  = scl_s2 & scl_p & ~sda_p & sda_s2;
    assign byte_in   = {shift[6:0], sda_s2};
    assign addr_hit  = (shift[7:1] == SLAVE_ADDR);
    assign last_rise = scl_rise && (cnt == 4'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start_det)     state_nx = ADDR;
        else if (stop_det) state_nx = IDLE;
        else begin
            unique case (state)
                ADDR: if (cnt == 4'd8) begin
                    if (!addr_hit)     state_nx = IGNORE;
                    else if (scl_fall) state_nx = ADDR_ACK;
                end
                ADDR_ACK: if (scl_fall) state_nx = rw ? RD_DATA : WR_DATA;
                WR_DATA:  if (scl_fall && cnt == 4'd8) state_nx = WR_ACK;
                WR_ACK:   if (scl_fall) state_nx = WR_DATA;
                RD_DATA:  if (scl_fall && cnt == 4'd8) state_nx = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s2) state_nx = IGNORE;
                    else if (scl_fall)      state_nx = RD_DATA;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift    <= '0;
            cnt      <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            if (start_det) begin
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (stop_det) begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                unique case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= byte_in;
                            if (cnt != 4'd8) cnt <= cnt + 4'd1;
                        end
                        if (last_rise && byte_in[7:1] == SLAVE_ADDR) begin
                            rw   <= byte_in[0];
                            busy <= 1'b1;
                        end
                        if (cnt == 4'd8 && addr_hit && scl_fall) sda_oe <= 1'b1;
                    end
                    ADDR_ACK, RD_ACK: if (scl_fall && (state == RD_ACK || rw)) begin
                        cnt     <= '0;
                        shift   <= tx_data;
                        tx_load <= 1'b1;
                        sda_oe  <= ~tx_data[7];
                    end else if (scl_fall) begin
                        cnt    <= '0;
                        sda_oe <= 1'b0;
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift <= byte_in;
                            if (cnt != 4'd8) cnt <= cnt + 4'd1;
                        end
                        if (last_rise) begin
                            rx_data  <= byte_in;
                            rx_valid <= 1'b1;
                        end
                        if (scl_fall && cnt == 4'd8) sda_oe <= 1'b1;
                    end
                    WR_ACK: if (scl_fall) begin
                        sda_oe <= 1'b0;
                        cnt    <= '0;
                    end
                    RD_DATA: begin
                        if (scl_rise && cnt != 4'd8) cnt <= cnt + 4'd1;
                        if (scl_fall) begin
                            if (cnt == 4'd8) sda_oe <= 1'b0;
                            else begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // Bus conditions gate the drive combinationally so SDA lets go in the detection cycle.
    always_comb begin
        sda_low = sda_oe && !start_det && !stop_det;
    end

    assign I2C_SDA = sda_low ? 1'b0 : 1'bz;

endmodule
